// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with register-file write port, WB->ID bypass
// and a retired-instruction counter.
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_valid,
    input  logic          mem_regwrite,
    input  logic          mem_memtoreg,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_alu_result,
    input  logic [DW-1:0] mem_rdata,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic [AW-1:0] write_reg,
    output logic [DW-1:0] write_data,
    output logic          regwrite,
    output logic [DW-1:0] id_rs_data,
    output logic [DW-1:0] id_rt_data,
    output logic          wb_valid,
    output logic [CW-1:0] retire_cnt
);

    logic          r_wb_valid;
    logic          r_wb_regwrite;
    logic [AW-1:0] r_wb_rd;
    logic [DW-1:0] r_wb_data;
    logic [CW-1:0] r_retire_cnt;

    logic [DW-1:0] w_mem_data;
    logic          w_regwrite;
    logic          w_leave;

    assign w_mem_data = mem_memtoreg ? mem_rdata : mem_alu_result;
    // The WB instruction leaves the stage when it is replaced or bubbled.
    assign w_leave    = r_wb_valid & (~stall | flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
        end else if (flush) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
        end else if (!stall) begin
            r_wb_valid    <= mem_valid;
            r_wb_regwrite <= mem_regwrite;
            r_wb_rd       <= mem_rd;
            r_wb_data     <= w_mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_leave) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign w_regwrite = r_wb_valid & r_wb_regwrite & (r_wb_rd != '0);

    assign regwrite   = w_regwrite;
    assign write_reg  = r_wb_rd;
    assign write_data = r_wb_data;
    assign wb_valid   = r_wb_valid;
    assign retire_cnt = r_retire_cnt;

    // w_regwrite already excludes r0, so index 0 always reads the raw file.
    assign id_rs_data = (w_regwrite && (id_rs == r_wb_rd)) ? r_wb_data : rf_rdata1;
    assign id_rt_data = (w_regwrite && (id_rt == r_wb_rd)) ? r_wb_data : rf_rdata2;

endmodule
